// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM encoding, default widths.
package alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NREG   = 8;
  localparam int DEF_AW     = 3;
  localparam int DEF_CTRL_W = 4;

  // ALU opcodes; everything above OP_LAST_LEGAL is illegal and yields 0 / carry 0.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_NAND = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  localparam logic [3:0] OP_LT   = 4'b1011;
  localparam logic [3:0] OP_EQ   = 4'b1100;

  localparam logic [3:0] OP_LAST_LEGAL = OP_EQ;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: r0 hardwired to zero, two operand read ports, one debug read port,
// one synchronous write port (the parent muxes writeback and debug writes onto it).
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int AW     = DEF_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] mem [NREG];

  // Storage: cleared on reset, writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational reads; r0 forced to zero independent of storage contents.
  always_comb begin
    rdata1    = (raddr1 == '0)    ? '0 : mem[raddr1];
    rdata2    = (raddr2 == '0)    ? '0 : mem[raddr2];
    dbg_rdata = (dbg_raddr == '0) ? '0 : mem[dbg_raddr];
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage around the combinational ALU: accept op, read operands, drive the ALU
// for one cycle, capture its result, write it back and report it downstream.
//
// Handshake: an op transfers on a rising edge where in_valid=1 and in_ready=1.
// in_ready depends only on the FSM state (1 in IDLE), never on in_valid. While
// in_valid=1 and in_ready=0 the upstream holds in_* stable; in_* are otherwise
// ignored. done_valid is a one-cycle pulse with no back-pressure.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int AW     = DEF_AW,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              done_valid,
  output logic [AW-1:0]     done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              done_illegal,
  output logic              carry_flag,
  input  logic              dbg_we,
  input  logic [AW-1:0]     dbg_waddr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output state_t            dbg_state
);

  state_t            state, state_next;
  logic [CTRL_W-1:0] op_ctrl;
  logic [AW-1:0]     op_rd;
  logic [DATA_W-1:0] op_x, op_y;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              wb_we;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

  // Writeback owns the write port in WB; debug writes are only honoured in IDLE,
  // so the two can never collide and WB always wins.
  assign rf_we     = wb_we | (dbg_we & (state == IDLE));
  assign rf_waddr  = wb_we ? op_rd    : dbg_waddr;
  assign rf_wdata  = wb_we ? res_data : dbg_wdata;
  assign dbg_state = state;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr1    (in_rs1),
    .raddr2    (in_rs2),
    .dbg_raddr (dbg_raddr),
    .rdata1    (rf_rdata1),
    .rdata2    (rf_rdata2),
    .dbg_rdata (dbg_rdata)
  );

  // State register plus the op/result latches and the sticky carry flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_ctrl    <= '0;
      op_rd      <= '0;
      op_x       <= '0;
      op_y       <= '0;
      res_data   <= '0;
      res_carry  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      state <= state_next;
      // Operands are sampled pre-edge, so a same-edge debug write is not seen.
      if ((state == IDLE) && in_valid) begin
        op_ctrl <= in_ctrl;
        op_rd   <= in_rd;
        op_x    <= rf_rdata1;
        op_y    <= rf_rdata2;
      end
      if (state == EXEC) begin
        res_data  <= alu_out;
        res_carry <= alu_carry;
      end
      if (state == WB) begin
        carry_flag <= res_carry;
      end
    end
  end

  // Next-state and per-state outputs; everything idles at zero except in_ready.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    alu_ctrl     = '0;
    alu_x        = '0;
    alu_y        = '0;
    done_valid   = 1'b0;
    done_rd      = '0;
    done_data    = '0;
    done_illegal = 1'b0;
    wb_we        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: begin
        alu_ctrl   = op_ctrl;
        alu_x      = op_x;
        alu_y      = op_y;
        state_next = WB;
      end
      WB: begin
        done_valid   = 1'b1;
        done_rd      = op_rd;
        done_data    = res_data;
        done_illegal = (op_ctrl > CTRL_W'(OP_LAST_LEGAL));
        wb_we        = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU, vector table, scoreboard on done_*,
// hand-written sequences for debug-write collisions and mid-op reset.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int W = 12; // {rd[2:0], data[7:0], illegal}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       in_valid, in_ready;
  logic [3:0] in_ctrl;
  logic [2:0] in_rs1, in_rs2, in_rd;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       done_valid, done_illegal, carry_flag;
  logic [2:0] done_rd;
  logic [7:0] done_data;
  logic       dbg_we;
  logic [2:0] dbg_waddr, dbg_raddr;
  logic [7:0] dbg_wdata, dbg_rdata;
  state_t     dbg_state;

  alu_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .alu_ctrl     (alu_ctrl),
    .alu_x        (alu_x),
    .alu_y        (alu_y),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry),
    .done_valid   (done_valid),
    .done_rd      (done_rd),
    .done_data    (done_data),
    .done_illegal (done_illegal),
    .carry_flag   (carry_flag),
    .dbg_we       (dbg_we),
    .dbg_waddr    (dbg_waddr),
    .dbg_wdata    (dbg_wdata),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata),
    .dbg_state    (dbg_state)
  );

  // Datapath ALU model. SUB reports a signed borrow (x < y as signed) on carry;
  // shifts move y by x[2:0]; illegal opcodes give 0 / carry 0.
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_ctrl)
      OP_ADD:  {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
      OP_SUB:  begin
        alu_out   = alu_x - alu_y;
        alu_carry = ($signed(alu_x) < $signed(alu_y));
      end
      OP_AND:  alu_out = alu_x & alu_y;
      OP_OR:   alu_out = alu_x | alu_y;
      OP_NOR:  alu_out = ~(alu_x | alu_y);
      OP_XOR:  alu_out = alu_x ^ alu_y;
      OP_SRL:  alu_out = alu_y >> alu_x[2:0];
      OP_SLL:  alu_out = alu_y << alu_x[2:0];
      OP_SRA:  alu_out = $unsigned($signed(alu_y) >>> alu_x[2:0]);
      OP_NAND: alu_out = ~(alu_x & alu_y);
      OP_XNOR: alu_out = ~(alu_x ^ alu_y);
      OP_LT:   alu_out = {7'd0, (alu_x < alu_y)};
      OP_EQ:   alu_out = {7'd0, (alu_x == alu_y)};
      default: ;
    endcase
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int hs_cyc = 0;
  logic last_carry = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every done_valid cycle must match the oldest pending expectation
  // and arrive exactly one cycle after its handshake.
  always @(negedge clk) begin
    if (done_valid) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("done_payload", {20'd0, done_rd, done_data, done_illegal}, {20'd0, e});
        check("done_latency", cyc - hs_cyc, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [1:0] ld_en;
    logic [2:0] la;
    logic [7:0] lda;
    logic [2:0] lb;
    logic [7:0] ldb;
    logic [3:0] ctrl;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_ill;
  } vec_t;

  // Called at a negedge; returns at the following negedge.
  task automatic dbg_write(input logic [2:0] a, input logic [7:0] d);
    dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_reg(input string name, input logic [2:0] a, input logic [7:0] e);
    dbg_raddr = a;
    #1;
    check(name, {24'd0, dbg_rdata}, {24'd0, e});
  endtask

  // One op, starting in IDLE near a negedge. dmode: 0 none, 1 debug write on the
  // handshake edge, 2 debug write held through EXEC, 3 held through WB.
  task automatic run_op(input vec_t v, input int dmode, input logic [2:0] da, input logic [7:0] dd);
    int n;
    in_valid = 1'b1; in_ctrl = v.ctrl; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
    if (dmode == 1) begin dbg_we = 1'b1; dbg_waddr = da; dbg_wdata = dd; end
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_alu_zero", {20'd0, alu_ctrl, alu_x}, 32'd0);
    @(posedge clk); #1;
    hs_cyc = cyc;
    exp_q.push_back({v.rd, v.exp_data, v.exp_ill});
    in_valid = 1'b0; dbg_we = 1'b0;
    in_ctrl = $urandom_range(0, 15); in_rs1 = $urandom_range(0, 7);
    in_rs2 = $urandom_range(0, 7);   in_rd = $urandom_range(0, 7);
    if (dmode == 2) begin dbg_we = 1'b1; dbg_waddr = da; dbg_wdata = dd; end
    @(negedge clk);
    check("exec_ready_low", {31'd0, in_ready}, 32'd0);
    check("exec_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, v.ctrl});
    check("exec_carry_hold", {31'd0, carry_flag}, {31'd0, last_carry});
    @(posedge clk); #1;
    dbg_we = 1'b0;
    if (dmode == 3) begin dbg_we = 1'b1; dbg_waddr = da; dbg_wdata = dd; end
    @(negedge clk);
    check("wb_ready_low", {31'd0, in_ready}, 32'd0);
    check("wb_carry_hold", {31'd0, carry_flag}, {31'd0, last_carry});
    @(posedge clk); #1;
    dbg_we = 1'b0;
    @(negedge clk);
    check("post_ready", {31'd0, in_ready}, 32'd1);
    check("post_done_low", {31'd0, done_valid}, 32'd0);
    check("carry_flag", {31'd0, carry_flag}, {31'd0, v.exp_carry});
    last_carry = v.exp_carry;
    expect_reg("rd_value", v.rd, (v.rd == 3'd0) ? 8'h00 : v.exp_data);
  endtask

  // ---------------- test ----------------
  vec_t vecs [10];
  vec_t hv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0; dbg_raddr = '0;

    //            ld    la    lda    lb    ldb    ctrl     rs1   rs2   rd    data   c     ill
    vecs[0] = '{2'b11, 3'd1, 8'hF0, 3'd2, 8'h20, OP_ADD,  3'd1, 3'd2, 3'd3, 8'h10, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, OP_SUB,  3'd2, 3'd1, 3'd4, 8'h30, 1'b0, 1'b0};
    vecs[2] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, OP_SUB,  3'd3, 3'd2, 3'd4, 8'hF0, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 3'd5, 8'h03, 3'd6, 8'h11, OP_SLL,  3'd5, 3'd6, 3'd7, 8'h88, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, OP_XOR,  3'd7, 3'd6, 3'd1, 8'h99, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 3'd1, 8'h05, 3'd2, 8'h06, OP_ADD,  3'd1, 3'd2, 3'd0, 8'h0B, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 3'd3, 8'h80, 3'd4, 8'h80, OP_ADD,  3'd3, 3'd4, 3'd5, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 4'b1111, 3'd1, 3'd2, 3'd2, 8'h00, 1'b0, 1'b1};
    vecs[8] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, OP_EQ,   3'd1, 3'd1, 3'd6, 8'h01, 1'b0, 1'b0};
    vecs[9] = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 4'b1101, 3'd1, 3'd1, 3'd6, 8'h00, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("rst_done", {20'd0, done_valid, done_rd, done_data}, 32'd0);
    check("rst_illegal", {31'd0, done_illegal}, 32'd0);
    check("rst_carry", {31'd0, carry_flag}, 32'd0);
    check("rst_alu", {12'd0, alu_ctrl, alu_x, alu_y}, 32'd0);
    expect_reg("rst_r1", 3'd1, 8'h00);
    @(negedge clk);

    // Table: loads then op; ops run back to back (next handshake at the first legal edge).
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ld_en[0]) dbg_write(vecs[i].la, vecs[i].lda);
      if (vecs[i].ld_en[1]) dbg_write(vecs[i].lb, vecs[i].ldb);
      run_op(vecs[i], 0, 3'd0, 8'h00);
    end
    expect_reg("r0_zero", 3'd0, 8'h00);
    @(negedge clk);
    dbg_write(3'd0, 8'h5A);
    expect_reg("r0_dbg_drop", 3'd0, 8'h00);

    // Debug write on the handshake edge: operands are read before the write.
    dbg_write(3'd2, 8'h06);
    hv = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, OP_ADD, 3'd1, 3'd2, 3'd3, 8'h0B, 1'b0, 1'b0};
    run_op(hv, 1, 3'd1, 8'h77);
    expect_reg("hs_dbg_written", 3'd1, 8'h77);

    // Debug write during EXEC is ignored.
    hv = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, OP_ADD, 3'd1, 3'd3, 3'd4, 8'h82, 1'b0, 1'b0};
    run_op(hv, 2, 3'd5, 8'hAA);
    expect_reg("exec_dbg_ignored", 3'd5, 8'h00);

    // Debug write to rd during WB: writeback wins.
    hv = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, OP_ADD, 3'd4, 3'd4, 3'd4, 8'h04, 1'b1, 1'b0};
    run_op(hv, 3, 3'd4, 8'h55);

    // Reset while the op sits in EXEC: discarded, no write, state cleared.
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = OP_ADD; in_rs1 = 3'd1; in_rs2 = 3'd3; in_rd = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_exec", {30'd0, dbg_state}, {30'd0, EXEC});
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_carry = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_done", {31'd0, done_valid}, 32'd0);
    check("rst_mid_carry", {31'd0, carry_flag}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      dbg_raddr = 3'(r);
      #0.5;
      check("rst_mid_reg", {24'd0, dbg_rdata}, 32'd0);
    end
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_no_done", {31'd0, done_valid}, 32'd0);
    end

    // Normal operation resumes after reset.
    dbg_write(3'd1, 8'h01);
    hv = '{2'b00, 3'd0, 8'h00, 3'd0, 8'h00, OP_ADD, 3'd1, 3'd1, 3'd2, 8'h02, 1'b0, 1'b0};
    run_op(hv, 0, 3'd0, 8'h00);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
